uart_host_seq: RTL and testbench

Host-side sequencer that sits directly upstream of the UART 16550 top and drives its register port (`wr`, `rd`, `addr`, `din`, `dout`). After reset it programs the divisor, line control and FIFO control registers. It then polls LSR continuously and turns the register interface into two valid/ready byte streams: TX bytes go to THR and RX bytes come from RBR. Line errors reported in LSR are surfaced as a one-cycle flag pulse.

---
 rtl/uart_host_seq.sv | 163 ++++++++++++++++
 tb/tb_uart_host_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_seq.sv
// Host-side sequencer for the UART 16550 register port: programs the divisor and line/FIFO
// control after reset, then polls LSR and bridges RBR/THR to valid/ready byte streams.
module uart_host_seq #(
    parameter logic [15:0] DIV      = 16'd27,
    parameter logic [7:0]  LCR_CFG  = 8'h03,
    parameter logic [7:0]  FCR_CFG  = 8'h07,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       uart_wr,
    output logic       uart_rd,
    output logic [2:0] uart_addr,
    output logic [7:0] uart_din,
    input  logic [7:0] uart_dout,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       init_done,
    output logic       err_valid,
    output logic [3:0] err_flags
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_GAP     = 3'd1;
    localparam logic [2:0] S_LSR_RD  = 3'd2;
    localparam logic [2:0] S_LSR_CAP = 3'd3;
    localparam logic [2:0] S_RBR_RD  = 3'd4;
    localparam logic [2:0] S_RBR_CAP = 3'd5;
    localparam logic [2:0] S_THR_WR  = 3'd6;

    // With no poll gap the idle state collapses straight into the next LSR read.
    localparam logic [2:0] S_IDLE   = (POLL_GAP == 0) ? S_LSR_RD : S_GAP;
    localparam logic [7:0] GAP_LOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    logic [2:0] state, state_nx;
    logic [2:0] step;
    logic [7:0] gap_cnt;
    logic       pri;
    logic       rx_ok, tx_ok, take_rx, take_tx;

    function automatic logic [2:0] init_addr(input logic [2:0] s);
        case (s)
            3'd0:    init_addr = 3'd3;
            3'd1:    init_addr = 3'd0;
            3'd2:    init_addr = 3'd1;
            3'd3:    init_addr = 3'd3;
            3'd4:    init_addr = 3'd2;
            default: init_addr = 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [2:0] s);
        case (s)
            3'd0:    init_data = 8'h80;
            3'd1:    init_data = DIV[7:0];
            3'd2:    init_data = DIV[15:8];
            3'd3:    init_data = LCR_CFG & 8'h7F;
            3'd4:    init_data = FCR_CFG;
            default: init_data = 8'h00;
        endcase
    endfunction

    // LSR is consumed straight off uart_dout at the end of LSR_CAP so the decision costs no extra cycle.
    always_comb begin
        state_nx = state;
        rx_ok    = uart_dout[0] & ~rx_valid;
        tx_ok    = uart_dout[5] & tx_valid;
        take_rx  = 1'b0;
        take_tx  = 1'b0;
        case (state)
            S_INIT:    if (step == 3'd6) state_nx = S_IDLE;
            S_GAP:     if (gap_cnt == 8'd0) state_nx = S_LSR_RD;
            S_LSR_RD:  state_nx = S_LSR_CAP;
            S_LSR_CAP: begin
                take_rx = rx_ok & (~tx_ok | ~pri);
                take_tx = tx_ok & ~take_rx;
                if (take_rx)      state_nx = S_RBR_RD;
                else if (take_tx) state_nx = S_THR_WR;
                else              state_nx = S_IDLE;
            end
            S_RBR_RD:  state_nx = S_RBR_CAP;
            S_RBR_CAP: state_nx = S_IDLE;
            S_THR_WR:  state_nx = S_IDLE;
            default:   state_nx = S_INIT;
        endcase
    end

    // Outputs are registered from the next state, so each state's strobes appear in its own cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            step      <= 3'd0;
            gap_cnt   <= 8'd0;
            pri       <= 1'b0;
            uart_wr   <= 1'b0;
            uart_rd   <= 1'b0;
            uart_addr <= 3'd0;
            uart_din  <= 8'h00;
            tx_ready  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            init_done <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 4'h0;
        end else begin
            state    <= state_nx;
            uart_wr  <= 1'b0;
            uart_rd  <= 1'b0;
            tx_ready <= 1'b0;

            if (state == S_INIT && step != 3'd6) step <= step + 3'd1;
            if (state == S_INIT && step == 3'd6) init_done <= 1'b1;

            if (state_nx == S_GAP && state != S_GAP) gap_cnt <= GAP_LOAD;
            else if (state == S_GAP)                 gap_cnt <= gap_cnt - 8'd1;

            case (state_nx)
                S_INIT: begin
                    uart_wr   <= 1'b1;
                    uart_addr <= init_addr(step);
                    uart_din  <= init_data(step);
                end
                S_LSR_RD: begin
                    uart_rd   <= 1'b1;
                    uart_addr <= 3'd5;
                end
                S_LSR_CAP: uart_addr <= 3'd5;
                S_RBR_RD: begin
                    uart_rd   <= 1'b1;
                    uart_addr <= 3'd0;
                end
                S_RBR_CAP: uart_addr <= 3'd0;
                S_THR_WR: begin
                    uart_wr   <= 1'b1;
                    uart_addr <= 3'd0;
                    uart_din  <= tx_data;
                    tx_ready  <= 1'b1;
                end
                default: ;
            endcase

            if (state == S_LSR_CAP) begin
                err_valid <= |uart_dout[4:1];
                if (|uart_dout[4:1]) err_flags <= uart_dout[4:1];
                if (take_rx | take_tx) pri <= ~pri;
            end else begin
                err_valid <= 1'b0;
            end

            if (state == S_RBR_CAP) begin
                rx_data  <= uart_dout;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_host_seq.sv
// Bench for uart_host_seq: a small UART register-port model behind the DUT, a cycle table for
// the init/poll phase, and directed sequences for TX, RX hold, alternation, errors and reset.
module tb_uart_host_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_wr, uart_rd;
    logic [2:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout = 8'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       init_done, err_valid;
    logic [3:0] err_flags;

    logic [7:0] lsr_m = 8'h00;
    logic [7:0] rbr_m = 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_host_seq dut (
        .clk(clk), .rst(rst),
        .uart_wr(uart_wr), .uart_rd(uart_rd), .uart_addr(uart_addr),
        .uart_din(uart_din), .uart_dout(uart_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .err_valid(err_valid), .err_flags(err_flags)
    );

    // UART side: a read strobe presents the addressed register on dout in the following cycle.
    always @(posedge clk)
        if (uart_rd) uart_dout <= (uart_addr == 3'd5) ? lsr_m : rbr_m;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] ctl;      // {wr, rd, tx_ready, rx_valid, err_valid, init_done}
        logic       chk_addr;
        logic [2:0] addr;
        logic       chk_din;
        logic [7:0] din;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got, cnt, ev;
        vecs[0]  = '{1'b1, 6'b000000, 1'b1, 3'd0, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 6'b100000, 1'b1, 3'd3, 1'b1, 8'h80};
        vecs[2]  = '{1'b0, 6'b100000, 1'b1, 3'd0, 1'b1, 8'h1B};
        vecs[3]  = '{1'b0, 6'b100000, 1'b1, 3'd1, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 6'b100000, 1'b1, 3'd3, 1'b1, 8'h03};
        vecs[5]  = '{1'b0, 6'b100000, 1'b1, 3'd2, 1'b1, 8'h07};
        vecs[6]  = '{1'b0, 6'b100000, 1'b1, 3'd1, 1'b1, 8'h00};
        for (int i = 7; i <= 10; i++) vecs[i] = '{1'b0, 6'b000001, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 6'b010001, 1'b1, 3'd5, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 6'b000001, 1'b1, 3'd5, 1'b0, 8'h00};
        for (int i = 13; i <= 16; i++) vecs[i] = '{1'b0, 6'b000001, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 6'b010001, 1'b1, 3'd5, 1'b0, 8'h00};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i),
                  {uart_wr, uart_rd, tx_ready, rx_valid, err_valid, init_done}, vecs[i].ctl);
            if (vecs[i].chk_addr) check($sformatf("vec%0d_addr", i), uart_addr, vecs[i].addr);
            if (vecs[i].chk_din)  check($sformatf("vec%0d_din", i), uart_din, vecs[i].din);
        end

        // TX stream 00..0F with THR always empty
        lsr_m = 8'h60;
        cnt = 0;
        for (int b = 0; b < 16; b++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(b);
            got = 0;
            for (int c = 0; c < 40 && got == 0; c++) begin
                @(negedge clk);
                if (uart_wr && uart_addr == 3'd0) cnt++;
                if (tx_ready) got = 1;
            end
            check($sformatf("tx_byte%0d", b), {got[0], uart_wr, uart_addr, uart_din},
                  {1'b1, 1'b1, 3'd0, 8'(b)});
        end
        tx_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (uart_wr && uart_addr == 3'd0) cnt++;
        end
        check("tx_wr_count", cnt, 16);

        // RX hold with back-pressure
        lsr_m = 8'h61;
        rbr_m = 8'h3C;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (rx_valid) got = 1;
        end
        check("rx_first", {got[0], rx_data}, {1'b1, 8'h3C});
        cnt = 0;
        got = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (uart_rd && uart_addr == 3'd0) cnt++;
            if (!rx_valid || rx_data != 8'h3C) got = 0;
        end
        check("rx_hold", got, 1);
        check("rx_no_read", cnt, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_clear", rx_valid, 1'b0);
        got = 0;
        for (int c = 0; c < 30 && got == 0; c++) begin
            @(negedge clk);
            if (uart_rd && uart_addr == 3'd0) got = 1;
        end
        check("rx_next_read", got, 1);

        // Both directions pending from reset: RX first, then strict alternation
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ev = 0;
        for (int c = 0; c < 400 && ev < 6; c++) begin
            @(negedge clk);
            if (init_done && uart_addr == 3'd0 && (uart_rd || uart_wr)) begin
                check($sformatf("alt%0d", ev), {uart_wr, uart_rd}, ev[0] ? 2'b10 : 2'b01);
                ev++;
            end
        end
        tx_valid = 1'b0;
        check("alt_count", ev, 6);

        // Error flags: OE and FE with data ready
        lsr_m = 8'h0B;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            got = 0;
            for (int c = 0; c < 20 && got == 0; c++) begin
                @(negedge clk);
                if (uart_rd && uart_addr == 3'd5) got = 1;
            end
            @(negedge clk);
            @(negedge clk);
            check($sformatf("err%0d", k), {got[0], err_valid, err_flags, uart_rd, uart_addr},
                  {1'b1, 1'b1, 4'b0101, 1'b1, 3'd0});
            @(negedge clk);
            check($sformatf("err%0d_once", k), err_valid, 1'b0);
        end

        // Reset during RBR_RD, then during the third init write
        lsr_m = 8'h61;
        got = 0;
        for (int c = 0; c < 30 && got == 0; c++) begin
            @(negedge clk);
            if (init_done && uart_rd && uart_addr == 3'd0) got = 1;
        end
        check("rst_found_rbr", got, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rbr_zero", {uart_wr, uart_rd, uart_addr, uart_din, tx_ready, rx_data, rx_valid,
                               init_done, err_valid, err_flags}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("reinit_w0", {uart_wr, uart_addr, uart_din}, {1'b1, 3'd3, 8'h80});
        @(negedge clk);
        @(negedge clk);
        check("reinit_w2", {uart_wr, uart_addr, uart_din}, {1'b1, 3'd1, 8'h00});
        rst = 1'b1;
        @(negedge clk);
        check("rst_init_zero", {uart_wr, uart_rd, uart_addr, uart_din, tx_ready, rx_data, rx_valid,
                                init_done, err_valid, err_flags}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("reinit2_w0", {uart_wr, uart_addr, uart_din}, {1'b1, 3'd3, 8'h80});
        repeat (6) @(negedge clk);
        check("reinit2_done", {init_done, rx_valid, uart_wr}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
